// File: rtl/aes_mix_columns_unit.sv
// Purpose : forward/inverse AES MixColumns over an NB-column state, COLS_PER_CYCLE columns per clock.
// Latency : NB/COLS_PER_CYCLE edges from accept to out_valid (bypass: out_valid right after the accept edge).
// Backpr. : one state in flight; in_ready low while BUSY/DONE, result held stable until out_ready.
//
// Optional feature macro: AES_MIXCOL_BYPASS_EN (adds the 'bypass' input for the final AES round).
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       text/inv_mode(/bypass) valid
//   in_ready       unit can accept a state (combinational from FSM state only)
//   inv_mode       0 = MixColumns, 1 = InvMixColumns; sampled on accept
//   bypass         (AES_MIXCOL_BYPASS_EN only) 1 = pass text straight to the output
//   text           input state, column c = text[32*NB-1-32*c -: 32], row 0 in the MSB byte
//   out_valid      modified_text valid
//   out_ready      consumer takes the result
//   modified_text  result, same column/row layout as text
module aes_mix_columns_unit #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inv_mode,
`ifdef AES_MIXCOL_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic [32*NB-1:0]  text,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  modified_text
);

    // Counter is one bit wider than a column index so it can reach NB.
    localparam int CW = $clog2(NB) + 1;
    localparam int IW = $clog2(NB);

    // Ascending packed index puts column 0 in the MSBs, matching the text layout.
    typedef logic [0:NB-1][31:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } fsm_e;

    // ------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11B
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // 09/0B/0D/0E are sums of b, 2b, 4b and 8b taken from one xtime chain.
    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Forward column mix: 03*a = xtime(a) ^ a.
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        r1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        r2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        r3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {r0, r1, r2, r3};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_e                state_q, state_d;
    state_t              work_q, work_nxt;
    logic                inv_q;
    logic [CW-1:0]       cnt_q, cnt_nxt;
    logic [32*NB-1:0]    out_q;
    logic                accept;
    logic                last_step;
    logic                bypass_sel;

`ifdef AES_MIXCOL_BYPASS_EN
    assign bypass_sel = bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    assign cnt_nxt   = cnt_q + CW'(COLS_PER_CYCLE);
    // cnt_q is always a multiple of COLS_PER_CYCLE, so this group is the final one.
    assign last_step = (cnt_nxt == CW'(NB));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = bypass_sel ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // No accept here: the unit returns to IDLE first.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_valid     = (state_q == ST_DONE);
    assign modified_text = out_q;

    // ------------------------------------------------------------------
    // Column transform for the current group, written back in place
    // ------------------------------------------------------------------
    always_comb begin
        work_nxt = work_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            // Low IW bits address the column; the group never crosses NB-1.
            work_nxt[cnt_q[IW-1:0] + IW'(k)] =
                inv_q ? mix_inv(work_q[cnt_q[IW-1:0] + IW'(k)])
                      : mix_fwd(work_q[cnt_q[IW-1:0] + IW'(k)]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            inv_q  <= 1'b0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            if (accept) begin
                work_q <= text;
                inv_q  <= inv_mode;
                cnt_q  <= '0;
                if (bypass_sel) begin
                    out_q <= text;
                end
            end else if (state_q == ST_BUSY) begin
                work_q <= work_nxt;
                if (last_step) begin
                    cnt_q <= '0;
                    out_q <= work_nxt;
                end else begin
                    cnt_q <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_mix_columns_unit.sv
// Purpose : self-checking bench for aes_mix_columns_unit in three geometries (NB4/CPC1, NB4/CPC4, NB8/CPC2).
// Latency : expected result and edge count come from a GF(2^8) matrix model in the bench.
// Backpr. : exercises held outputs under out_ready=0, mid-op reset and back-to-back traffic.
module tb_aes_mix_columns_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // DUT A: NB=4, CPC=1
    logic         a_in_valid, a_in_ready, a_inv, a_out_valid, a_out_ready;
    logic [127:0] a_text, a_mt;
    // DUT B: NB=4, CPC=4
    logic         b_in_valid, b_in_ready, b_inv, b_out_valid, b_out_ready;
    logic [127:0] b_text, b_mt;
    // DUT C: NB=8, CPC=2
    logic         c_in_valid, c_in_ready, c_inv, c_out_valid, c_out_ready;
    logic [255:0] c_text, c_mt;
`ifdef AES_MIXCOL_BYPASS_EN
    logic         a_bypass = 1'b0;
    logic         b_bypass = 1'b0;
    logic         c_bypass = 1'b0;
`endif

    aes_mix_columns_unit #(.NB(4), .COLS_PER_CYCLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .inv_mode(a_inv),
`ifdef AES_MIXCOL_BYPASS_EN
        .bypass(a_bypass),
`endif
        .text(a_text), .out_valid(a_out_valid), .out_ready(a_out_ready), .modified_text(a_mt));

    aes_mix_columns_unit #(.NB(4), .COLS_PER_CYCLE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .inv_mode(b_inv),
`ifdef AES_MIXCOL_BYPASS_EN
        .bypass(b_bypass),
`endif
        .text(b_text), .out_valid(b_out_valid), .out_ready(b_out_ready), .modified_text(b_mt));

    aes_mix_columns_unit #(.NB(8), .COLS_PER_CYCLE(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .inv_mode(c_inv),
`ifdef AES_MIXCOL_BYPASS_EN
        .bypass(c_bypass),
`endif
        .text(c_text), .out_valid(c_out_valid), .out_ready(c_out_ready), .modified_text(c_mt));

    localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] T2_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] T2_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [255:0] T5_IN  = {T1_IN,  128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6};
    localparam logic [255:0] T5_OUT = {T1_OUT, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6};
    localparam int BOUND = 200;

    // ------------------------------------------------------------------
    // Reference model: carry-less product reduced by 0x11B, circulant matrix per column
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p ^= (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // State is right-aligned in the 256-bit container; width is 32*nb.
    function automatic logic [255:0] mix_model(input logic [255:0] st, input int nb, input logic inv);
        logic [7:0]   coef [4];
        logic [255:0] res;
        logic [31:0]  col;
        logic [7:0]   acc;
        res = '0;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < nb; c++) begin
            col = st[32*nb-1-32*c -: 32];
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc ^= gf_mul(coef[(j - i + 4) % 4], col[31-8*j -: 8]);
                res[32*nb-1-32*c-8*i -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ------------------------------------------------------------------
    // One transaction per DUT: accept, count edges to out_valid, take result
    // ------------------------------------------------------------------
    task automatic a_xact(input logic [127:0] t, input logic m, output logic [127:0] r, output int lat);
        logic [255:0] junk;
        @(negedge clk);
        a_text = t; a_inv = m; a_in_valid = 1'b1;
        @(posedge clk); #1;
        junk = rand256();
        a_in_valid = 1'b0; a_text = junk[127:0]; a_inv = ~m;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= BOUND) begin
            checks++; failures++;
            $display("FAIL a_timeout: out_valid not seen within %0d edges", BOUND);
        end
        r = a_mt;
        @(negedge clk); a_out_ready = 1'b1;
        @(posedge clk); #1; a_out_ready = 1'b0;
    endtask

    task automatic b_xact(input logic [127:0] t, input logic m, output logic [127:0] r, output int lat);
        logic [255:0] junk;
        @(negedge clk);
        b_text = t; b_inv = m; b_in_valid = 1'b1;
        @(posedge clk); #1;
        junk = rand256();
        b_in_valid = 1'b0; b_text = junk[127:0]; b_inv = ~m;
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= BOUND) begin
            checks++; failures++;
            $display("FAIL b_timeout: out_valid not seen within %0d edges", BOUND);
        end
        r = b_mt;
        @(negedge clk); b_out_ready = 1'b1;
        @(posedge clk); #1; b_out_ready = 1'b0;
    endtask

    task automatic c_xact(input logic [255:0] t, input logic m, output logic [255:0] r, output int lat);
        @(negedge clk);
        c_text = t; c_inv = m; c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0; c_text = rand256(); c_inv = ~m;
        lat = 0;
        while (c_out_valid !== 1'b1 && lat < BOUND) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= BOUND) begin
            checks++; failures++;
            $display("FAIL c_timeout: out_valid not seen within %0d edges", BOUND);
        end
        r = c_mt;
        @(negedge clk); c_out_ready = 1'b1;
        @(posedge clk); #1; c_out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_inv = 0; a_out_ready = 0; a_text = '0;
        b_in_valid = 0; b_inv = 0; b_out_ready = 0; b_text = '0;
        c_in_valid = 0; c_inv = 0; c_out_ready = 0; c_text = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_mt !== '0) begin
            failures++;
            $display("FAIL reset_a: in_ready=%b out_valid=%b mt=%h, want 1 0 0", a_in_ready, a_out_valid, a_mt);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_mt !== '0) begin
            failures++;
            $display("FAIL reset_b: in_ready=%b out_valid=%b mt=%h, want 1 0 0", b_in_ready, b_out_valid, b_mt);
        end
        checks++;
        if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0 || c_mt !== '0) begin
            failures++;
            $display("FAIL reset_c: in_ready=%b out_valid=%b mt=%h, want 1 0 0", c_in_ready, c_out_valid, c_mt);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, want 1 0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_fwd_nb4_cpc1();
        logic [127:0] r;
        int lat;
        a_xact(T1_IN, 1'b0, r, lat);
        checks++;
        if (r !== T1_OUT) begin
            failures++; $display("FAIL t1_data: got %h want %h", r, T1_OUT);
        end
        checks++;
        if (lat !== 4) begin
            failures++; $display("FAIL t1_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_inv_nb4_cpc4();
        logic [127:0] r;
        int lat;
        b_xact(T2_IN, 1'b1, r, lat);
        checks++;
        if (r !== T2_OUT) begin
            failures++; $display("FAIL t2_data: got %h want %h", r, T2_OUT);
        end
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL t2_latency: got %0d want 1", lat);
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [255:0] junk;
        @(negedge clk);
        a_text = T1_IN; a_inv = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        w = 0;
        while (a_out_valid !== 1'b1 && w < BOUND) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (w >= BOUND) begin
            failures++; $display("FAIL t3_timeout: out_valid not seen within %0d edges", BOUND);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            junk = rand256();
            a_in_valid = junk[0]; a_inv = junk[1]; a_text = junk[255:128];
            @(posedge clk); #1;
            checks++;
            if (a_out_valid !== 1'b1 || a_mt !== T1_OUT || a_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL t3_hold[%0d]: out_valid=%b in_ready=%b mt=%h, want 1 0 %h",
                         i, a_out_valid, a_in_ready, a_mt, T1_OUT);
            end
        end
        // Release with in_valid high: the DONE edge must not also accept.
        @(negedge clk);
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t3_release: out_valid=%b in_ready=%b, want 0 1", a_out_valid, a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t3_no_accept: out_valid=%b in_ready=%b, want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [127:0] r;
        int lat;
        int bad;
        @(negedge clk);
        a_text = T1_IN; a_inv = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;        // second BUSY cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_mt !== '0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL t4_async: out_valid=%b in_ready=%b mt=%h, want 0 1 0", a_out_valid, a_in_ready, a_mt);
        end
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_mt !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL t4_stale: %0d cycles with output activity, want 0", bad);
        end
        a_xact(T1_IN, 1'b0, r, lat);
        checks++;
        if (r !== T1_OUT || lat !== 4) begin
            failures++; $display("FAIL t4_recover: got %h lat %0d want %h lat 4", r, lat, T1_OUT);
        end
    endtask

    task automatic test_nb8_cpc2();
        logic [255:0] r, back;
        int lat;
        c_xact(T5_IN, 1'b0, r, lat);
        checks++;
        if (r !== T5_OUT) begin
            failures++; $display("FAIL t5_data: got %h want %h", r, T5_OUT);
        end
        checks++;
        if (lat !== 4) begin
            failures++; $display("FAIL t5_latency: got %0d want 4", lat);
        end
        c_xact(r, 1'b1, back, lat);
        checks++;
        if (back !== T5_IN) begin
            failures++; $display("FAIL t5_roundtrip: got %h want %h", back, T5_IN);
        end
    endtask

    task automatic test_random();
        logic [255:0] t, exp256, r256, back256;
        logic [127:0] r128, back128, exp128;
        logic         m;
        int           lat;
        for (int n = 0; n < 12; n++) begin
            t = rand256(); m = t[0];
            exp256 = mix_model({128'h0, t[255:128]}, 4, m);
            exp128 = exp256[127:0];
            a_xact(t[255:128], m, r128, lat);
            checks++;
            if (r128 !== exp128 || lat !== 4) begin
                failures++; $display("FAIL rand_a[%0d]: got %h lat %0d want %h lat 4", n, r128, lat, exp128);
            end
            a_xact(r128, ~m, back128, lat);
            checks++;
            if (back128 !== t[255:128]) begin
                failures++; $display("FAIL rand_a_rt[%0d]: got %h want %h", n, back128, t[255:128]);
            end

            t = rand256(); m = t[3];
            exp256 = mix_model({128'h0, t[127:0]}, 4, m);
            exp128 = exp256[127:0];
            b_xact(t[127:0], m, r128, lat);
            checks++;
            if (r128 !== exp128 || lat !== 1) begin
                failures++; $display("FAIL rand_b[%0d]: got %h lat %0d want %h lat 1", n, r128, lat, exp128);
            end

            t = rand256(); m = t[7];
            exp256 = mix_model(t, 8, m);
            c_xact(t, m, r256, lat);
            checks++;
            if (r256 !== exp256 || lat !== 4) begin
                failures++; $display("FAIL rand_c[%0d]: got %h lat %0d want %h lat 4", n, r256, lat, exp256);
            end
            c_xact(r256, ~m, back256, lat);
            checks++;
            if (back256 !== t) begin
                failures++; $display("FAIL rand_c_rt[%0d]: got %h want %h", n, back256, t);
            end
        end
    endtask

    // Continuous traffic on DUT B: one state every NB/CPC+2 = 3 cycles.
    task automatic test_back_to_back();
        logic [127:0] expq [$];
        logic [255:0] junk, e;
        logic [127:0] want;
        int n_in, n_out, bad;
        n_in = 0; n_out = 0; bad = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            junk = rand256();
            b_text = junk[127:0]; b_inv = junk[200]; b_in_valid = 1'b1; b_out_ready = 1'b1;
            if (b_in_ready === 1'b1) begin
                e = mix_model({128'h0, junk[127:0]}, 4, junk[200]);
                expq.push_back(e[127:0]);
                n_in++;
            end
            if (b_out_valid === 1'b1) begin
                n_out++;
                if (expq.size() == 0) begin
                    bad++;
                end else begin
                    want = expq.pop_front();
                    if (b_mt !== want) begin
                        bad++;
                        $display("FAIL b2b_data: got %h want %h", b_mt, want);
                    end
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL b2b_results: %0d bad results, want 0", bad);
        end
        checks++;
        if (n_in != 10 || n_out != 10) begin
            failures++; $display("FAIL b2b_throughput: in=%0d out=%0d, want 10 10", n_in, n_out);
        end
        // Drain whatever is still in flight.
        b_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); b_out_ready = 1'b0;
    endtask

`ifdef AES_MIXCOL_BYPASS_EN
    task automatic test_bypass();
        logic [255:0] t;
        logic [127:0] r;
        logic [255:0] r256;
        int lat;
        for (int n = 0; n < 4; n++) begin
            t = rand256();
            a_bypass = 1'b1;
            a_xact(t[127:0], t[200], r, lat);
            a_bypass = 1'b0;
            checks++;
            if (r !== t[127:0] || lat !== 0) begin
                failures++; $display("FAIL bypass_a[%0d]: got %h lat %0d want %h lat 0", n, r, lat, t[127:0]);
            end
            c_bypass = 1'b1;
            c_xact(t, t[5], r256, lat);
            c_bypass = 1'b0;
            checks++;
            if (r256 !== t || lat !== 0) begin
                failures++; $display("FAIL bypass_c[%0d]: got %h lat %0d want %h lat 0", n, r256, lat, t);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fwd_nb4_cpc1();
        test_inv_nb4_cpc4();
        test_backpressure();
        test_reset_mid_op();
        test_nb8_cpc2();
        test_random();
        test_back_to_back();
`ifdef AES_MIXCOL_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
